// File: rtl/oldland_exec_mdu.sv
// Multi-cycle unsigned multiply/divide unit beside the execute ALU.
// One op at a time; iterates one bit per cycle and strobes done for writeback.
module oldland_exec_mdu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned RD_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         opc,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [RD_BITS-1:0] rd_sel,
  input  logic               cancel,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [RD_BITS-1:0] rd_sel_out,
  output logic               z_flag,
  output logic               n_flag,
  output logic               div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           opc_q, opc_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  // Product for multiply; low half doubles as dividend/quotient shifter for divide.
  logic [PW-1:0]        prod_q, prod_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [RD_BITS-1:0]   rd_q, rd_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 z_q, z_d;
  logic                 n_q, n_d;
  logic                 dz_q, dz_d;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [WIDTH-1:0]     fin;
  logic                 load;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opc_q    <= opc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      dz_q     <= dz_d;
    end
  end

  // Next-state and iteration logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opc_d    = opc_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    rd_d     = rd_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    dz_d     = dz_q;
    fin      = '0;
    load     = 1'b0;

    mul_sum   = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    div_shift = {rem_q, prod_q[WIDTH-1]};
    // Borrow out lands in the top bit because the remainder is always below the divisor.
    div_diff  = div_shift - {1'b0, b_q};

    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          opc_d  = opc;
          a_d    = op_a;
          b_d    = op_b;
          rd_d   = rd_sel;
          cnt_d  = '0;
          rem_d  = '0;
          prod_d = {{WIDTH{1'b0}}, (opc[1] ? op_a : op_b)};
          if (opc[1] && (op_b == '0)) begin
            fin     = (opc == OP_REMU) ? op_a : {WIDTH{1'b1}};
            dz_d    = 1'b1;
            load    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!opc_q[1]) begin
            prod_d = {mul_sum, prod_q[WIDTH-1:1]};
          end else if (div_diff[WIDTH]) begin
            rem_d              = div_shift[WIDTH-1:0];
            prod_d[WIDTH-1:0]  = {prod_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_d              = div_diff[WIDTH-1:0];
            prod_d[WIDTH-1:0]  = {prod_q[WIDTH-2:0], 1'b1};
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_DONE;
            load    = 1'b1;
            dz_d    = 1'b0;
            case (opc_q)
              OP_MUL:   fin = prod_d[WIDTH-1:0];
              OP_MULHU: fin = prod_d[PW-1:WIDTH];
              OP_DIVU:  fin = prod_d[WIDTH-1:0];
              default:  fin = rem_d;
            endcase
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      result_d = fin;
      z_d      = (fin == '0);
      n_d      = fin[WIDTH-1];
    end
  end

  assign stall      = ((state_q == S_IDLE) && start && !cancel) || (state_q == S_RUN);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) && !cancel;
  assign result     = result_q;
  assign rd_sel_out = rd_q;
  assign z_flag     = z_q;
  assign n_flag     = n_q;
  assign div_zero   = dz_q;

endmodule

// File: tb/tb_oldland_exec_mdu.sv
// Self-checking bench for oldland_exec_mdu: scoreboarded ops, latency, cancel and reset.
module tb_oldland_exec_mdu;

  localparam int unsigned W  = 32;
  localparam int unsigned RB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    opc = 2'b00;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [RB-1:0] rd_sel = '0;
  logic          cancel = 1'b0;
  logic          stall, busy, done, z_flag, n_flag, div_zero;
  logic [W-1:0]  result;
  logic [RB-1:0] rd_sel_out;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [RB-1:0] rd;
    logic          z;
    logic          n;
    logic          dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  logic stall0;

  oldland_exec_mdu #(.WIDTH(W), .RD_BITS(RB)) dut (
    .clk(clk), .rst(rst), .start(start), .opc(opc), .op_a(op_a), .op_b(op_b),
    .rd_sel(rd_sel), .cancel(cancel), .stall(stall), .busy(busy), .done(done),
    .result(result), .rd_sel_out(rd_sel_out), .z_flag(z_flag), .n_flag(n_flag),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [RB-1:0] rd);
    logic [2*W-1:0] p;
    exp_t e;
    p    = (2*W)'(a) * (2*W)'(b);
    e.dz = 1'b0;
    case (o)
      2'd0: e.res = p[W-1:0];
      2'd1: e.res = p[2*W-1:W];
      2'd2: if (b == '0) begin e.res = '1; e.dz = 1'b1; end else e.res = a / b;
      default: if (b == '0) begin e.res = a; e.dz = 1'b1; end else e.res = a % b;
    endcase
    e.rd = rd;
    e.z  = (e.res == '0);
    e.n  = e.res[W-1];
    return e;
  endfunction

  // Present one op for a single edge (edge 0) and record its expectation.
  task automatic drive_start(input logic [1:0] o, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [RB-1:0] rd);
    @(negedge clk);
    start = 1'b1; opc = o; op_a = a; op_b = b; rd_sel = rd;
    sb.push_back(model(o, a, b, rd));
    #1 stall0 = stall;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count cycles after edge 0 until done; lat = 0 on timeout.
  task automatic wait_done(input int limit, output int lat, output bit stall_ok);
    bit found;
    lat = 0; stall_ok = 1'b1; found = 1'b0;
    for (int c = 1; c <= limit && !found; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        lat   = c;
        if (stall !== 1'b0) stall_ok = 1'b0;
      end else if (stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, stall} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {busy, done, stall});
    else passed++;
    checks++;
    if ({result, rd_sel_out, z_flag, n_flag, div_zero} !== '0)
      $display("FAIL reset_outs: got %h/%h/%b%b%b want all zero", result, rd_sel_out, z_flag, n_flag, div_zero);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat; bit sok; exp_t e;
    drive_start(2'd0, 32'd7, 32'd6, 4'd3);
    checks++;
    if (stall0 !== 1'b1) $display("FAIL mul_stall_c0: got %b want 1", stall0); else passed++;
    wait_done(60, lat, sok);
    e = sb.pop_front();
    checks++;
    if (lat != 33) $display("FAIL mul_latency: got %0d want 33", lat); else passed++;
    checks++;
    if (!sok) $display("FAIL mul_stall_run: got 0 want 1"); else passed++;
    checks++;
    if ({result, rd_sel_out, z_flag, n_flag, div_zero} !== {e.res, e.rd, e.z, e.n, e.dz})
      $display("FAIL mul_7x6: got %h rd %h z%b n%b dz%b want %h rd %h", result, rd_sel_out, z_flag, n_flag, div_zero, e.res, e.rd);
    else passed++;
  endtask

  task automatic test_mulhu();
    int lat; bit sok; exp_t e;
    drive_start(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9);
    wait_done(60, lat, sok);
    e = sb.pop_front();
    checks++;
    if ({result, n_flag, z_flag} !== {e.res, e.n, e.z})
      $display("FAIL mulhu_ff: got %h n%b z%b want %h n%b", result, n_flag, z_flag, e.res, e.n);
    else passed++;
    drive_start(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
    wait_done(60, lat, sok);
    e = sb.pop_front();
    checks++;
    if ({result, rd_sel_out} !== {e.res, e.rd})
      $display("FAIL mul_ff: got %h rd %h want %h rd %h", result, rd_sel_out, e.res, e.rd);
    else passed++;
    drive_start(2'd0, 32'h1234_5678, 32'h9ABC_DEF1, 4'd7);
    wait_done(60, lat, sok);
    e = sb.pop_front();
    checks++;
    if (result !== e.res) $display("FAIL mul_mixed: got %h want %h", result, e.res); else passed++;
  endtask

  task automatic test_div();
    int lat; bit sok; exp_t e;
    logic [1:0]   ops [4] = '{2'd2, 2'd3, 2'd3, 2'd2};
    logic [W-1:0] as  [4] = '{32'd100, 32'd100, 32'd21, 32'hF000_0001};
    logic [W-1:0] bs  [4] = '{32'd7, 32'd7, 32'd7, 32'd3};
    for (int i = 0; i < 4; i++) begin
      drive_start(ops[i], as[i], bs[i], RB'(i + 4));
      wait_done(60, lat, sok);
      e = sb.pop_front();
      checks++;
      if ({lat == 33, result, rd_sel_out, z_flag, n_flag, div_zero} !== {1'b1, e.res, e.rd, e.z, e.n, e.dz})
        $display("FAIL div_%0d: got lat %0d %h z%b n%b dz%b want %h z%b n%b", i, lat, result, z_flag, n_flag, div_zero, e.res, e.z, e.n);
      else passed++;
    end
  endtask

  task automatic test_div_zero();
    int lat; bit sok; exp_t e;
    drive_start(2'd2, 32'd5, 32'd0, 4'd1);
    wait_done(60, lat, sok);
    e = sb.pop_front();
    checks++;
    if (lat != 1) $display("FAIL divz_latency: got %0d want 1", lat); else passed++;
    checks++;
    if ({result, div_zero} !== {e.res, e.dz})
      $display("FAIL divu_zero: got %h dz%b want %h dz%b", result, div_zero, e.res, e.dz);
    else passed++;
    drive_start(2'd3, 32'd5, 32'd0, 4'd8);
    wait_done(60, lat, sok);
    e = sb.pop_front();
    checks++;
    if ({lat == 1, result, div_zero, rd_sel_out} !== {1'b1, e.res, e.dz, e.rd})
      $display("FAIL remu_zero: got lat %0d %h dz%b want %h dz%b", lat, result, div_zero, e.res, e.dz);
    else passed++;
  endtask

  task automatic test_cancel();
    int lat; bit sok, saw; exp_t e;
    drive_start(2'd0, 32'd11, 32'd13, 4'd6);
    void'(sb.pop_back());
    repeat (9) @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) $display("FAIL cancel_idle: got %b want 00", {busy, done}); else passed++;
    saw = 1'b0;
    repeat (40) @(negedge clk) if (done === 1'b1) saw = 1'b1;
    checks++;
    if (saw) $display("FAIL cancel_no_done: got 1 want 0"); else passed++;
    // start and cancel together in IDLE: nothing captured
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; opc = 2'd0; op_a = 32'd3; op_b = 32'd3;
    #1 stall0 = stall;
    @(posedge clk);
    #1 begin start = 1'b0; cancel = 1'b0; end
    @(negedge clk);
    checks++;
    if ({stall0, busy} !== 2'b00) $display("FAIL cancel_start: got %b want 00", {stall0, busy}); else passed++;
    drive_start(2'd2, 32'd9, 32'd3, 4'd12);
    wait_done(60, lat, sok);
    e = sb.pop_front();
    checks++;
    if ({result, rd_sel_out} !== {e.res, e.rd})
      $display("FAIL after_cancel_div: got %h rd %h want %h rd %h", result, rd_sel_out, e.res, e.rd);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat; bit sok; exp_t e;
    drive_start(2'd2, 32'd1000, 32'd10, 4'd5);
    repeat (4) @(negedge clk);
    @(negedge clk);
    start = 1'b1; opc = 2'd0; op_a = 32'd3; op_b = 32'd3; rd_sel = 4'd9;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(60, lat, sok);
    e = sb.pop_front();
    checks++;
    if (lat != 28) $display("FAIL busy_start_latency: got %0d want 28", lat); else passed++;
    checks++;
    if ({result, rd_sel_out} !== {e.res, e.rd})
      $display("FAIL busy_start_ignored: got %h rd %h want %h rd %h", result, rd_sel_out, e.res, e.rd);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit saw;
    drive_start(2'd2, 32'd50, 32'd5, 4'd10);
    void'(sb.pop_back());
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, result, rd_sel_out, z_flag, n_flag, div_zero} !== '0)
      $display("FAIL reset_mid: got busy%b done%b %h rd %h want all zero", busy, done, result, rd_sel_out);
    else passed++;
    saw = 1'b0;
    repeat (40) @(negedge clk) if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
    checks++;
    if (saw) $display("FAIL reset_mid_quiet: got 1 want 0"); else passed++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulhu();
    test_div();
    test_div_zero();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/oldland_exec_mdu.md
Name: oldland_exec_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle execute ALU. It is the next-generation execute-stage arithmetic block.
- Accepts one operation at a time from decode/execute. Stalls the pipeline while iterating, then presents the result and destination register for writeback.
- Generalises the execute stage in two ways: configurable datapath width, and a start/busy/done handshake for ops that cannot finish in one cycle.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 4 and even.
- RD_BITS, 4, width of destination register selector.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- opc  input  2  operation: 00 MUL (low half), 01 MULHU (unsigned high half), 10 DIVU, 11 REMU.
- op_a  input  WIDTH  multiplicand / dividend.
- op_b  input  WIDTH  multiplier / divisor.
- rd_sel  input  RD_BITS  destination register, captured with start.
- cancel  input  1  abort in-flight op (branch/exception flush).
- stall  output  1  hold upstream pipeline.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle result-valid strobe.
- result  output  WIDTH  operation result; valid while done = 1.
- rd_sel_out  output  RD_BITS  destination register; valid with done.
- z_flag  output  1  result == 0; valid with done.
- n_flag  output  1  result[WIDTH-1]; valid with done.
- div_zero  output  1  DIVU/REMU with op_b == 0; valid with done.

Behaviour:
- Reset: state IDLE; done, busy, div_zero, z_flag, n_flag = 0; result = 0; rd_sel_out = 0; all internal registers cleared. Reset mid-operation discards the op with no done.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: start = 1 and cancel = 0, and the op is not a divide-by-zero. Capture opc, op_a, op_b, rd_sel; step counter = 0.
- IDLE -> DONE: start with DIVU/REMU and op_b == 0. No iteration.
  - DIVU result = all-ones; REMU result = op_a; div_zero = 1.
- RUN: one step per cycle, WIDTH steps. Counter increments each step and leaves RUN after step WIDTH-1, so there is no wrap.
  - Multiply: radix-2 shift-add into a 2*WIDTH product register; unsigned.
  - Divide: restoring, one quotient bit per cycle, unsigned; remainder kept WIDTH+1 bits wide.
- RUN -> DONE: after the final step.
  - result = low product (MUL), high product (MULHU), quotient (DIVU) or remainder (REMU).
  - z_flag and n_flag are computed from result; div_zero = 0.
- DONE -> IDLE: unconditional after one cycle. done = 1 only in DONE.
- Latency: start sampled at edge 0.
  - Normal op: done high during cycle WIDTH+1 (33 cycles for WIDTH = 32).
  - Divide-by-zero: done high in cycle 1.
- stall (combinational) = (IDLE & start & ~cancel) | RUN.
  - stall is low in DONE so the pipeline advances and captures the result that cycle.
- busy = (state != IDLE).
- start while busy is ignored; no queueing. Upstream must keep start asserted until stall drops.
- cancel:
  - In RUN or DONE: next state IDLE, done forced 0 that cycle, result discarded.
  - In IDLE together with start: cancel wins, nothing is captured.
- Arithmetic is modulo 2^WIDTH; MUL discards the high half. No signed variants.
- Outputs result, rd_sel_out, z_flag, n_flag and div_zero are registered. They hold their last values after done falls and are only defined while done = 1.

Test Plan:
- WIDTH = 32, start MUL op_a = 7, op_b = 6, rd_sel = 3 -> stall high for cycles 0..32; done = 1 in cycle 33 with result = 42, rd_sel_out = 3, z = 0, n = 0.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> result = 0xFFFFFFFE, n_flag = 1. Same operands with MUL -> result = 0x00000001.
- DIVU 100 / 7 -> result = 14. REMU 100 / 7 -> result = 2. REMU 21 / 7 -> result = 0, z_flag = 1.
- DIVU 5 / 0 -> done in cycle 1, result = 0xFFFFFFFF, div_zero = 1. REMU 5 / 0 -> result = 5, div_zero = 1.
- Start MUL, assert cancel in cycle 10 -> IDLE in cycle 11, no done pulse. A new DIVU 9 / 3 immediately after -> result = 3.
- Pulse start with different operands during RUN -> ignored; the original result is returned. Assert rst at cycle 5 of a divide -> busy = 0 and done = 0 thereafter, all outputs at reset values.
